ad5621_write: RTL and testbench

- Serial DAC writer for the transmit path. It accepts 12-bit samples over a valid/ready handshake and shifts each one into an AD5621-class 12-bit DAC.
- The DAC uses a 3-wire interface: SYNC#, SCLK and SDIN, with data latched on the SCLK falling edge.
- The block runs in the same 81.36 MHz domain as the ADC capture logic and mirrors its serial timing style: generated SCLK, cs-style framing, MSB-first.
- A one-entry input buffer lets the upstream present the next sample while the current frame shifts.

---
 rtl/ad5621_write.sv | 124 ++++++++++++
 tb/tb_ad5621_write.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5621_write.sv
// Serial writer for an AD5621-class 12-bit DAC: valid/ready sample intake with a one-entry
// buffer, 16-bit MSB-first frames on SYNC#/SCLK/SDIN with a generated SCLK that idles high.
module ad5621_write #(
  parameter int unsigned SCLK_DIV    = 1,
  parameter int unsigned IDLE_CYCLES = 3,
  parameter logic [1:0]  PD_MODE     = 2'b00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dac_data_en,
  input  logic [11:0] dac_data,
  output logic        dac_data_rdy,
  output logic        dac_busy,
  output logic        dac_syncn,
  output logic        dac_sclk,
  output logic        dac_sdin
);

  localparam logic [2:0] PhaseLast = 3'(SCLK_DIV - 1);
  localparam logic [3:0] GapLast   = 4'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e      state_q;
  logic [11:0] buf_q;
  logic        buf_valid_q;
  logic [14:0] shift_q;
  logic [3:0]  bit_cnt_q;
  logic [2:0]  phase_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic        syncn_q;
  logic        sclk_q;
  logic        sdin_q;
  logic        busy_q;
  logic        accept;

  // The buffer only takes a sample when empty, so accept and the IDLE load never coincide.
  assign accept = dac_data_en & ~buf_valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      buf_q       <= 12'h000;
      buf_valid_q <= 1'b0;
      shift_q     <= 15'h0000;
      bit_cnt_q   <= 4'd0;
      phase_cnt_q <= 3'd0;
      gap_cnt_q   <= 4'd0;
      syncn_q     <= 1'b1;
      sclk_q      <= 1'b1;
      sdin_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        buf_q       <= dac_data;
        buf_valid_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (buf_valid_q) begin
            state_q     <= StShift;
            // Frame bit 15 goes straight to sdin; shift_q holds bits 14..0.
            sdin_q      <= PD_MODE[1];
            shift_q     <= {PD_MODE[0], buf_q, 2'b00};
            buf_valid_q <= 1'b0;
            bit_cnt_q   <= 4'd15;
            phase_cnt_q <= 3'd0;
            syncn_q     <= 1'b0;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        StShift: begin
          if (phase_cnt_q != PhaseLast) begin
            phase_cnt_q <= phase_cnt_q + 3'd1;
          end else begin
            phase_cnt_q <= 3'd0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bit_cnt_q == 4'd0) begin
              state_q   <= StGap;
              gap_cnt_q <= 4'd0;
              syncn_q   <= 1'b1;
              sclk_q    <= 1'b1;
              sdin_q    <= 1'b0;
            end else begin
              // Next bit changes with the rising sclk, keeping sdin stable across the fall.
              bit_cnt_q <= bit_cnt_q - 4'd1;
              sclk_q    <= 1'b1;
              sdin_q    <= shift_q[14];
              shift_q   <= {shift_q[13:0], 1'b0};
            end
          end
        end

        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          syncn_q <= 1'b1;
          sclk_q  <= 1'b1;
          sdin_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_data_rdy = ~buf_valid_q;
  assign dac_busy     = busy_q;
  assign dac_syncn    = syncn_q;
  assign dac_sclk     = sclk_q;
  assign dac_sdin     = sdin_q;

endmodule

// File: tb/tb_ad5621_write.sv
// Directed bench for ad5621_write: a default instance and a SCLK_DIV=4 / PD_MODE=11 instance,
// frames decoded by sampling sdin on each falling sclk.
module tb_ad5621_write;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en0, en1;
  logic [11:0] d0, d1;
  logic        rdy0, busy0, syncn0, sclk0, sdin0;
  logic        rdy1, busy1, syncn1, sclk1, sdin1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sel      = 0;

  logic m_syncn, m_sclk, m_sdin;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_syncn = (sel == 1) ? syncn1 : syncn0;
  assign m_sclk  = (sel == 1) ? sclk1  : sclk0;
  assign m_sdin  = (sel == 1) ? sdin1  : sdin0;

  ad5621_write dut0 (
    .clk(clk), .rstn(rstn), .dac_data_en(en0), .dac_data(d0), .dac_data_rdy(rdy0),
    .dac_busy(busy0), .dac_syncn(syncn0), .dac_sclk(sclk0), .dac_sdin(sdin0)
  );

  ad5621_write #(.SCLK_DIV(4), .IDLE_CYCLES(3), .PD_MODE(2'b11)) dut1 (
    .clk(clk), .rstn(rstn), .dac_data_en(en1), .dac_data(d1), .dac_data_rdy(rdy1),
    .dac_busy(busy1), .dac_syncn(syncn1), .dac_sclk(sclk1), .dac_sdin(sdin1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the selected DUT's SYNC# to fall, then decodes one frame until SYNC# rises.
  task automatic capture(input int div, output logic [15:0] word, output int nbits,
                         output int low, output int fall_cyc, output int first_fall,
                         output int run_err, output int unstable, output bit to);
    int   n;
    int   run;
    logic prev_sclk;
    logic last_sdin;
    word = 16'h0; nbits = 0; low = 0; fall_cyc = 0; first_fall = -1;
    run_err = 0; unstable = 0; to = 1'b0; n = 0;
    while (m_syncn !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    if (m_syncn !== 1'b0) begin
      to = 1'b1;
      return;
    end
    fall_cyc  = cyc;
    low       = 1;
    run       = 1;
    prev_sclk = m_sclk;
    last_sdin = m_sdin;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (m_syncn === 1'b1) break;
      low++;
      if (m_sclk === prev_sclk) run++;
      else begin
        if (run != div) run_err++;
        run = 1;
      end
      if (prev_sclk === 1'b1 && m_sclk === 1'b0) begin
        word = {word[14:0], m_sdin};
        nbits++;
        if (first_fall < 0) first_fall = low - 1;
      end else if (prev_sclk === 1'b0 && m_sclk === 1'b0 && m_sdin !== last_sdin) begin
        unstable++;
      end
      prev_sclk = m_sclk;
      last_sdin = m_sdin;
    end
    if (run != div) run_err++;
    if (m_syncn !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en0 = 1'b0; en1 = 1'b0; d0 = 12'h0; d1 = 12'h0;
    #23;
    checks++; if (syncn0 !== 1'b1) begin failures++; $display("FAIL reset_syncn got=%b exp=1", syncn0); end
    checks++; if (sclk0 !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk0); end
    checks++; if (sdin0 !== 1'b0) begin failures++; $display("FAIL reset_sdin got=%b exp=0", sdin0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy0); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] w; int nb, low, fc, ff, re, us, acc; bit to;
    sel = 0;
    d0 = 12'hA5C; en0 = 1'b1;
    tick();
    acc = cyc; en0 = 1'b0;
    capture(1, w, nb, low, fc, ff, re, us, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
    checks++; if (w !== 16'h2970 || nb != 16) begin
      failures++; $display("FAIL single_word got=%h/%0d exp=2970/16", w, nb); end
    checks++; if (low != 32) begin failures++; $display("FAIL single_syncn_low got=%0d exp=32", low); end
    checks++; if (fc - acc != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", fc - acc); end
    checks++; if (ff != 1) begin failures++; $display("FAIL single_first_fall got=%0d exp=1", ff); end
    checks++; if (re != 0) begin failures++; $display("FAIL single_sclk_runs got=%0d exp=0", re); end
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL single_busy_gap got=%b exp=1", busy0); end
    repeat (3) tick();
    checks++; if (busy0 !== 1'b0 || syncn0 !== 1'b1 || sdin0 !== 1'b0) begin
      failures++; $display("FAIL single_idle_after got=%b%b%b exp=010", busy0, syncn0, sdin0); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals[3];
    logic [15:0] exp_w[3];
    logic [15:0] w[3];
    int fc[3];
    int accepts, rdy_err, stim_to;
    bit tos, done;
    vals  = '{12'h000, 12'hFFF, 12'h800};
    exp_w = '{16'h0000, 16'h3FFC, 16'h2000};
    accepts = 0; rdy_err = 0; stim_to = 0; tos = 1'b0; done = 1'b0;
    sel = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          n = 0;
          d0 = vals[i]; en0 = 1'b1;
          while (rdy0 !== 1'b1 && n < 200) begin tick(); n++; end
          if (n >= 200) stim_to++;
          tick();
        end
        en0 = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) begin
          int nb, low, ff, re, us; bit to;
          capture(1, w[f], nb, low, fc[f], ff, re, us, to);
          if (to || nb != 16) tos = 1'b1;
        end
        done = 1'b1;
      end
      begin
        bit bv, p_en, p_rdy, p_sync;
        bv = 1'b0; p_en = 1'b0; p_rdy = 1'b1; p_sync = 1'b1;
        while (!done) begin
          @(negedge clk);
          if (p_en && p_rdy) bv = 1'b1;
          if (p_sync && !syncn0) bv = 1'b0;
          if (rdy0 !== !bv) rdy_err++;
          if (en0 && rdy0) accepts++;
          p_en = en0; p_rdy = rdy0; p_sync = syncn0;
        end
      end
    join
    checks++; if (tos || stim_to != 0) begin
      failures++; $display("FAIL b2b_timeout got=%0d/%0d exp=0/0", tos, stim_to); end
    for (int f = 0; f < 3; f++) begin
      checks++; if (w[f] !== exp_w[f]) begin
        failures++; $display("FAIL b2b_word%0d got=%h exp=%h", f, w[f], exp_w[f]); end
    end
    for (int f = 1; f < 3; f++) begin
      checks++; if (fc[f] - fc[f-1] != 36) begin
        failures++; $display("FAIL b2b_period%0d got=%0d exp=36", f, fc[f] - fc[f-1]); end
    end
    checks++; if (accepts != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    checks++; if (rdy_err != 0) begin failures++; $display("FAIL b2b_rdy got=%0d exp=0", rdy_err); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w[2];
    int bp_err, extra;
    bit tos;
    bp_err = 0; extra = 0; tos = 1'b0;
    sel = 0;
    fork
      begin
        d0 = 12'h321; en0 = 1'b1;
        tick();
        en0 = 1'b0;
        tick();
        d0 = 12'h456; en0 = 1'b1;
        tick();
        d0 = 12'h111;
        repeat (10) begin
          if (rdy0 !== 1'b0) bp_err++;
          tick();
        end
        en0 = 1'b0;
      end
      begin
        for (int f = 0; f < 2; f++) begin
          int nb, low, fc, ff, re, us; bit to;
          capture(1, w[f], nb, low, fc, ff, re, us, to);
          if (to || nb != 16) tos = 1'b1;
        end
      end
    join
    repeat (100) begin
      tick();
      if (syncn0 !== 1'b1) extra++;
    end
    checks++; if (tos) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (w[0] !== 16'h0C84) begin failures++; $display("FAIL bp_word0 got=%h exp=0c84", w[0]); end
    checks++; if (w[1] !== 16'h1158) begin failures++; $display("FAIL bp_word1 got=%h exp=1158", w[1]); end
    checks++; if (bp_err != 0) begin failures++; $display("FAIL bp_rdy_full got=%0d exp=0", bp_err); end
    checks++; if (extra != 0) begin failures++; $display("FAIL bp_no_third got=%0d exp=0", extra); end
  endtask

  task automatic test_div4();
    logic [15:0] w; int nb, low, fc, ff, re, us; bit to;
    sel = 1;
    d1 = 12'h123; en1 = 1'b1;
    tick();
    en1 = 1'b0;
    capture(4, w, nb, low, fc, ff, re, us, to);
    checks++; if (to) begin failures++; $display("FAIL div4_timeout got=1 exp=0"); end
    checks++; if (w !== 16'hC48C || nb != 16) begin
      failures++; $display("FAIL div4_word got=%h/%0d exp=c48c/16", w, nb); end
    checks++; if (low != 128) begin failures++; $display("FAIL div4_syncn_low got=%0d exp=128", low); end
    checks++; if (re != 0) begin failures++; $display("FAIL div4_sclk_runs got=%0d exp=0", re); end
    checks++; if (us != 0) begin failures++; $display("FAIL div4_sdin_stable got=%0d exp=0", us); end
    checks++; if (ff != 4) begin failures++; $display("FAIL div4_first_fall got=%0d exp=4", ff); end
    sel = 0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] w; int nb, low, fc, ff, re, us, n, extra; bit to;
    sel = 0; n = 0; extra = 0;
    d0 = 12'hFFF; en0 = 1'b1;
    tick();
    while (rdy0 !== 1'b1 && n < 50) begin tick(); n++; end
    d0 = 12'hABC;
    tick();
    en0 = 1'b0;
    repeat (15) tick();
    // Bit 7 of 16'h3FFC is 1, so the drop of sdin to 0 below is visible.
    checks++; if (syncn0 !== 1'b0 || sdin0 !== 1'b1 || rdy0 !== 1'b0) begin
      failures++; $display("FAIL mid_pre_reset got=%b%b%b exp=010", syncn0, sdin0, rdy0); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (syncn0 !== 1'b1 || sclk0 !== 1'b1 || sdin0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0)
    begin
      failures++;
      $display("FAIL mid_async_reset got=%b%b%b%b%b exp=11010", syncn0, sclk0, sdin0, rdy0, busy0);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (100) begin
      tick();
      if (syncn0 !== 1'b1 || busy0 !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL mid_no_restart got=%0d exp=0", extra); end
    d0 = 12'h5A5; en0 = 1'b1;
    tick();
    en0 = 1'b0;
    capture(1, w, nb, low, fc, ff, re, us, to);
    checks++; if (to || w !== 16'h1694) begin
      failures++; $display("FAIL mid_next_word got=%h exp=1694", w); end
  endtask

  task automatic test_idle();
    int errs;
    errs = 0;
    repeat (1000) begin
      tick();
      if (syncn0 !== 1'b1 || sclk0 !== 1'b1 || busy0 !== 1'b0) errs++;
      if (syncn1 !== 1'b1 || sclk1 !== 1'b1 || busy1 !== 1'b0) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL idle_constant got=%0d exp=0", errs); end
  endtask

  initial begin
    test_reset();
    test_single();
    repeat (5) tick();
    test_back_to_back();
    repeat (5) tick();
    test_backpressure();
    test_div4();
    repeat (5) tick();
    test_reset_mid();
    repeat (5) tick();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
